// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state enum, register width, NOP encoding and a sizing helper.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   // wait counter must hold MAX_MEM_WAIT and is never narrower than 8 bits
   function automatic int wait_width(input int max_wait);
      int w;
      w = $clog2(max_wait + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Ports: clk, clr_n (async clear), en (count enable), count (current value).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, dmem waits.
// Ports: hazard inputs from ID/EX, branch_taken, dmem_busy; pipeline controls, err, stall_cycles.
module pipe_hazard_ctrl #(
   parameter int REG_W        = pipe_ctrl_pkg::REG_W,
   parameter int MAX_MEM_WAIT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ex_memread,
   input  logic [REG_W-1:0] id_ex_rt,
   input  logic [REG_W-1:0] if_id_rs,
   input  logic [REG_W-1:0] if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             branch_taken,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             if_id_stall,
   output logic             if_flush,
   output logic             id_ex_bubble,
   output logic             back_stall,
   output logic             err,
   output logic [CNT_W-1:0] stall_cycles
);

   import pipe_ctrl_pkg::*;

   localparam int WAIT_W = wait_width(MAX_MEM_WAIT);
   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_MEM_WAIT - 1);

   state_t            state, state_n;
   logic [WAIT_W-1:0] wait_cnt, wait_n;
   logic              err_n;

   logic load_use;
   logic in_rst, frz, lu, br, run;

   assign load_use = id_ex_memread
                   & (id_ex_rt != '0)
                   & ((id_ex_rt == if_id_rs)
                     | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
         err      <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      err_n   = err;
      unique case (state)
         RUN: begin
            if (dmem_busy) begin
               state_n = MEM_WAIT;
               wait_n  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_busy) begin
               if (wait_cnt >= LIMIT) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else begin
                  wait_n = wait_cnt + 1'b1;
               end
            end else begin
               state_n = RUN;
               wait_n  = '0;
            end
         end
         ERR: begin
            state_n = ERR;
            err_n   = 1'b1;
         end
         default: begin
            state_n = RUN;
            wait_n  = '0;
         end
      endcase
   end

   // one-hot priority terms so the decoder below is truly unique
   assign in_rst = ~reset;
   assign frz    = reset & ((state == ERR) | dmem_busy);
   assign lu     = reset & ~frz & load_use;
   assign br     = reset & ~frz & ~load_use & branch_taken;
   assign run    = reset & ~frz & ~load_use & ~branch_taken;

   always_comb begin
      pc_write     = 1'b1;
      if_id_stall  = 1'b0;
      if_flush     = 1'b0;
      id_ex_bubble = 1'b0;
      back_stall   = 1'b0;
      unique case (1'b1)
         in_rst: begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
         end
         frz: begin
            pc_write    = 1'b0;
            if_id_stall = 1'b1;
            back_stall  = 1'b1;
         end
         lu: begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
         end
         br: begin
            if_flush = 1'b1;
         end
         run: begin
            pc_write = 1'b1;
         end
         default: begin
            pc_write = 1'b1;
         end
      endcase
   end

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .clr_n(reset),
      .en   (~pc_write),
      .count(stall_cycles)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: default instance plus a short-timeout, 3-bit-count one.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic       memrd, usert, br, busy;
   logic [4:0] exrt, rs, rt;

   logic        a_pcw, a_stall, a_flush, a_bub, a_back, a_err;
   logic [15:0] a_cnt;
   logic        b_pcw, b_stall, b_flush, b_bub, b_back, b_err;
   logic [2:0]  b_cnt;

   pipe_hazard_ctrl dut_a (
      .clk          (clk),
      .reset        (rst_a),
      .id_ex_memread(memrd),
      .id_ex_rt     (exrt),
      .if_id_rs     (rs),
      .if_id_rt     (rt),
      .if_id_uses_rt(usert),
      .branch_taken (br),
      .dmem_busy    (busy),
      .pc_write     (a_pcw),
      .if_id_stall  (a_stall),
      .if_flush     (a_flush),
      .id_ex_bubble (a_bub),
      .back_stall   (a_back),
      .err          (a_err),
      .stall_cycles (a_cnt)
   );

   pipe_hazard_ctrl #(
      .MAX_MEM_WAIT(4),
      .CNT_W       (3)
   ) dut_b (
      .clk          (clk),
      .reset        (rst_b),
      .id_ex_memread(memrd),
      .id_ex_rt     (exrt),
      .if_id_rs     (rs),
      .if_id_rt     (rt),
      .if_id_uses_rt(usert),
      .branch_taken (br),
      .dmem_busy    (busy),
      .pc_write     (b_pcw),
      .if_id_stall  (b_stall),
      .if_flush     (b_flush),
      .id_ex_bubble (b_bub),
      .back_stall   (b_back),
      .err          (b_err),
      .stall_cycles (b_cnt)
   );

   // out = {pc_write, if_id_stall, if_flush, id_ex_bubble, back_stall, err}
   typedef struct packed {
      logic        sel;
      logic [5:0]  out;
      logic        chk;
      logic [15:0] cnt;
   } exp_t;

   localparam logic [5:0] O_RST = 6'b000100;
   localparam logic [5:0] O_RUN = 6'b100000;
   localparam logic [5:0] O_LU  = 6'b010100;
   localparam logic [5:0] O_BR  = 6'b101000;
   localparam logic [5:0] O_FRZ = 6'b010010;
   localparam logic [5:0] O_ERR = 6'b010011;

   exp_t  eq[$];
   string nq[$];
   int    checks = 0;
   int    errors = 0;

   exp_t        m_e;
   string       m_n;
   logic [5:0]  m_out;
   logic [15:0] m_cnt;

   always @(negedge clk) begin
      if (eq.size() > 0) begin
         m_e = eq.pop_front();
         m_n = nq.pop_front();
         if (m_e.sel) begin
            m_out = {b_pcw, b_stall, b_flush, b_bub, b_back, b_err};
            m_cnt = {13'd0, b_cnt};
         end else begin
            m_out = {a_pcw, a_stall, a_flush, a_bub, a_back, a_err};
            m_cnt = a_cnt;
         end
         checks++;
         if ((m_out !== m_e.out) || (m_e.chk && (m_cnt !== m_e.cnt))) begin
            errors++;
            $display("FAIL %s: got out=%b cnt=%0d, want out=%b cnt=%0d",
                     m_n, m_out, m_cnt, m_e.out, m_e.cnt);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic m, input logic [4:0] e, input logic [4:0] r,
                      input logic [4:0] t, input logic u, input logic b,
                      input logic y);
      memrd = m;
      exrt  = e;
      rs    = r;
      rt    = t;
      usert = u;
      br    = b;
      busy  = y;
   endtask

   task automatic exp(input logic s, input logic [5:0] o, input int n,
                      input string name);
      exp_t e;
      e.sel = s;
      e.out = o;
      e.chk = 1'b1;
      e.cnt = 16'(n);
      eq.push_back(e);
      nq.push_back(name);
   endtask

   task automatic idle();
      drv(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      idle();

      // instance A: default parameters
      cyc(); exp(0, O_RST, 0, "rst_hold0");
      cyc(); exp(0, O_RST, 0, "rst_hold1");
      cyc(); rst_a = 1'b1; exp(0, O_RUN, 0, "rst_release");

      cyc(); drv(1, 5'd8, 5'd8, 5'd0, 0, 0, 0); exp(0, O_LU, 0, "lu_rs");
      cyc(); drv(1, 5'd0, 5'd0, 5'd0, 1, 0, 0); exp(0, O_RUN, 1, "lu_rt0");
      cyc(); drv(1, 5'd8, 5'd3, 5'd8, 0, 0, 0); exp(0, O_RUN, 1, "lu_nouse");
      cyc(); drv(1, 5'd8, 5'd3, 5'd8, 1, 0, 0); exp(0, O_LU, 1, "lu_rt");
      cyc(); idle(); exp(0, O_RUN, 2, "idle0");

      cyc(); drv(0, 5'd0, 5'd0, 5'd0, 0, 1, 0); exp(0, O_BR, 2, "branch");
      cyc(); idle(); exp(0, O_RUN, 2, "branch_end");
      cyc(); drv(1, 5'd8, 5'd8, 5'd0, 0, 1, 0); exp(0, O_LU, 2, "branch_lu");
      cyc(); idle(); exp(0, O_RUN, 3, "idle1");

      for (int i = 0; i < 5; i++) begin
         cyc(); drv(0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
         exp(0, O_FRZ, 3 + i, $sformatf("memwait%0d", i));
      end
      cyc(); idle(); exp(0, O_RUN, 8, "memwait_exit");
      cyc(); idle(); exp(0, O_RUN, 8, "memwait_run");

      cyc(); drv(0, 5'd0, 5'd0, 5'd0, 0, 0, 1); exp(0, O_FRZ, 8, "mw_before_rst");
      cyc(); rst_a = 1'b0; exp(0, O_RST, 0, "mw_rst");
      cyc(); rst_a = 1'b1; idle(); exp(0, O_RUN, 0, "mw_rst_release");

      // instance B: MAX_MEM_WAIT = 4, CNT_W = 3
      cyc(); rst_a = 1'b0; rst_b = 1'b1; exp(1, O_RUN, 0, "b_release");
      for (int i = 0; i < 4; i++) begin
         cyc(); drv(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
         exp(1, O_FRZ, i, $sformatf("to_busy%0d", i));
      end
      for (int i = 0; i < 7; i++) begin
         cyc(); drv(0, 5'd0, 5'd0, 5'd0, 0, (i == 1), 0);
         exp(1, O_ERR, (4 + i > 7) ? 7 : 4 + i, $sformatf("to_err%0d", i));
      end
      cyc(); rst_b = 1'b0; idle(); exp(1, O_RST, 0, "b_rst");
      cyc(); rst_b = 1'b1; exp(1, O_RUN, 0, "b_rst_release");
      cyc(); drv(0, 5'd0, 5'd0, 5'd0, 0, 0, 1); exp(1, O_FRZ, 0, "b_busy");
      cyc(); idle(); exp(1, O_RUN, 1, "b_busy_end");

      for (int i = 0; i < 10 && eq.size() > 0; i++) @(negedge clk);
      #1;
      if (eq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", eq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
